// File: rtl/dsi_packet_parser.sv
// MIPI DSI byte-stream packet parser: decodes HSS/VSS short packets into sync
// pulses and unpacks RGB888 (DT 0x3E) long-packet payload into 24-bit pixels.
module dsi_packet_parser #(
    parameter logic [1:0] VC = 2'd0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        hs_active_i,
    input  logic [7:0]  byte_in_i,
    input  logic        byte_valid_i,
    output logic [23:0] pixel_data_o,
    output logic        pixel_valid_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        ecc_err_o,
    output logic        len_err_o,
    output logic        trunc_err_o
);

    typedef enum logic [2:0] {H0, H1, H2, H3, PAY, C0, C1} state_t;

    state_t      state_q, state_d;
    logic [7:0]  di_q, di_d, wclo_q, wclo_d, wchi_q, wchi_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  phase_q, phase_d;
    logic [7:0]  r_q, r_d, g_q, g_d;
    logic        pix_en_q, pix_en_d, len_bad_q, len_bad_d;
    logic [23:0] pixel_data_q, pixel_data_d;
    logic        pixel_valid_q, pixel_valid_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d;
    logic        ecc_err_q, ecc_err_d, len_err_q, len_err_d, trunc_err_q, trunc_err_d;

    logic        acc, trunc, is_long, vc_ok, ecc_ok;
    logic [5:0]  dt;
    logic [15:0] wc;

    assign acc     = byte_valid_i & hs_active_i;
    assign trunc   = ~hs_active_i & (state_q != H0);
    assign dt      = di_q[5:0];
    assign wc      = {wchi_q, wclo_q};
    assign vc_ok   = (di_q[7:6] == VC);
    assign ecc_ok  = (byte_in_i == (di_q ^ wclo_q ^ wchi_q));
    assign is_long = (dt == 6'h09) || (dt == 6'h19) || (dt == 6'h29) ||
                     (dt == 6'h39) || (dt == 6'h3E);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= H0;
            di_q          <= '0;
            wclo_q        <= '0;
            wchi_q        <= '0;
            cnt_q         <= '0;
            phase_q       <= '0;
            r_q           <= '0;
            g_q           <= '0;
            pix_en_q      <= 1'b0;
            len_bad_q     <= 1'b0;
            pixel_data_q  <= '0;
            pixel_valid_q <= 1'b0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            ecc_err_q     <= 1'b0;
            len_err_q     <= 1'b0;
            trunc_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            di_q          <= di_d;
            wclo_q        <= wclo_d;
            wchi_q        <= wchi_d;
            cnt_q         <= cnt_d;
            phase_q       <= phase_d;
            r_q           <= r_d;
            g_q           <= g_d;
            pix_en_q      <= pix_en_d;
            len_bad_q     <= len_bad_d;
            pixel_data_q  <= pixel_data_d;
            pixel_valid_q <= pixel_valid_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            ecc_err_q     <= ecc_err_d;
            len_err_q     <= len_err_d;
            trunc_err_q   <= trunc_err_d;
        end
    end

    // A burst ending mid-packet overrides any byte presented in the same cycle.
    always_comb begin
        state_d = state_q;
        if (trunc) begin
            state_d = H0;
        end else if (acc) begin
            case (state_q)
                H0:      state_d = H1;
                H1:      state_d = H2;
                H2:      state_d = H3;
                H3: begin
                    if (!ecc_ok || !is_long) state_d = H0;
                    else if (wc != 16'd0)    state_d = PAY;
                    else                     state_d = C0;
                end
                PAY:     if (cnt_q == 16'd1) state_d = C0;
                C0:      state_d = C1;
                default: state_d = H0;
            endcase
        end
    end

    always_comb begin
        di_d          = di_q;
        wclo_d        = wclo_q;
        wchi_d        = wchi_q;
        cnt_d         = cnt_q;
        phase_d       = phase_q;
        r_d           = r_q;
        g_d           = g_q;
        pix_en_d      = pix_en_q;
        len_bad_d     = len_bad_q;
        pixel_data_d  = pixel_data_q;
        pixel_valid_d = 1'b0;
        hsync_d       = 1'b0;
        vsync_d       = 1'b0;
        ecc_err_d     = 1'b0;
        len_err_d     = 1'b0;
        trunc_err_d   = trunc;
        if (!trunc && acc) begin
            case (state_q)
                H0: di_d   = byte_in_i;
                H1: wclo_d = byte_in_i;
                H2: wchi_d = byte_in_i;
                H3: begin
                    if (!ecc_ok) begin
                        ecc_err_d = 1'b1;
                    end else if (is_long) begin
                        cnt_d     = wc;
                        phase_d   = 2'd0;
                        pix_en_d  = vc_ok && (dt == 6'h3E);
                        len_bad_d = (wc % 16'd3) != 16'd0;
                    end else if (vc_ok) begin
                        vsync_d = (dt == 6'h01);
                        hsync_d = (dt == 6'h21);
                    end
                end
                PAY: begin
                    cnt_d = cnt_q - 16'd1;
                    if (pix_en_q) begin
                        case (phase_q)
                            2'd0: begin r_d = byte_in_i; phase_d = 2'd1; end
                            2'd1: begin g_d = byte_in_i; phase_d = 2'd2; end
                            default: begin
                                pixel_data_d  = {r_q, g_q, byte_in_i};
                                pixel_valid_d = 1'b1;
                                phase_d       = 2'd0;
                            end
                        endcase
                    end
                    if (cnt_q == 16'd1) len_err_d = pix_en_q & len_bad_q;
                end
                default: ;
            endcase
        end
    end

    assign pixel_data_o  = pixel_data_q;
    assign pixel_valid_o = pixel_valid_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign ecc_err_o     = ecc_err_q;
    assign len_err_o     = len_err_q;
    assign trunc_err_o   = trunc_err_q;

endmodule

// File: tb/tb_dsi_packet_parser.sv
// Directed bench for dsi_packet_parser: sync pulses, RGB888 unpacking, ECC,
// length and truncation errors, VC filtering and asynchronous reset.
module tb_dsi_packet_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hs_active = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic [23:0] pixel_data;
    logic        pixel_valid, hsync, vsync, ecc_err, len_err, trunc_err;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    dsi_packet_parser #(.VC(2'd0)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .hs_active_i   (hs_active),
        .byte_in_i     (byte_in),
        .byte_valid_i  (byte_valid),
        .pixel_data_o  (pixel_data),
        .pixel_valid_o (pixel_valid),
        .hsync_o       (hsync),
        .vsync_o       (vsync),
        .ecc_err_o     (ecc_err),
        .len_err_o     (len_err),
        .trunc_err_o   (trunc_err)
    );

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Presents one byte; returns 1ns after the edge that accepted it.
    task automatic send(input logic [7:0] b);
        hs_active  = 1'b1;
        byte_in    = b;
        byte_valid = 1'b1;
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic idle();
        byte_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_hdr(input logic [7:0] di, input logic [7:0] lo,
                            input logic [7:0] hi, input logic [7:0] ecc);
        send(di); send(lo); send(hi); send(ecc);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pd"}, pixel_data, 24'h0);
        chk({tag, "_flags"}, {18'h0, pixel_valid, hsync, vsync, ecc_err, len_err, trunc_err}, 24'h0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        idle();
        chk_all_zero("post_reset");

        $display("txn VSS 01 00 00 01");
        send_hdr(8'h01, 8'h00, 8'h00, 8'h01);
        chk("vss_vsync", vsync, 1);
        chk("vss_hsync", hsync, 0);
        chk("vss_ecc", ecc_err, 0);
        $display("txn HSS 21 00 00 21");
        send(8'h21);
        chk("vss_pulse_1cyc", vsync, 0);
        send(8'h00); send(8'h00); send(8'h21);
        chk("hss_hsync", hsync, 1);
        chk("hss_vsync", vsync, 0);
        idle();
        chk("hss_pulse_1cyc", hsync, 0);

        $display("txn RGB888 WC=6 AABBCC 112233");
        send_hdr(8'h3E, 8'h06, 8'h00, 8'h38);
        chk("rgb_hdr_nopix", pixel_valid, 0);
        send(8'hAA); send(8'hBB);
        chk("rgb_no_early_pix", pixel_valid, 0);
        send(8'hCC);
        chk("rgb_pix0_valid", pixel_valid, 1);
        chk("rgb_pix0_data", pixel_data, 24'hAABBCC);
        send(8'h11);
        chk("rgb_strobe_1cyc", pixel_valid, 0);
        chk("rgb_data_hold", pixel_data, 24'hAABBCC);
        send(8'h22); send(8'h33);
        chk("rgb_pix1_valid", pixel_valid, 1);
        chk("rgb_pix1_data", pixel_data, 24'h112233);
        chk("rgb_no_len_err", len_err, 0);
        send(8'h5A); send(8'hA5);
        chk("rgb_crc_nopix", pixel_valid, 0);
        $display("txn VSS after long packet");
        send_hdr(8'h01, 8'h00, 8'h00, 8'h01);
        chk("rgb_back_to_h0", vsync, 1);

        $display("txn HSS with bad ECC 21 00 00 20");
        send_hdr(8'h21, 8'h00, 8'h00, 8'h20);
        chk("bad_ecc_flag", ecc_err, 1);
        chk("bad_ecc_no_hsync", hsync, 0);
        $display("txn VSS after bad ECC");
        send_hdr(8'h01, 8'h00, 8'h00, 8'h01);
        chk("after_ecc_vsync", vsync, 1);
        chk("after_ecc_clear", ecc_err, 0);

        $display("txn RGB888 WC=4 010203 04");
        send_hdr(8'h3E, 8'h04, 8'h00, 8'h3A);
        send(8'h01); send(8'h02); send(8'h03);
        chk("len_pix_valid", pixel_valid, 1);
        chk("len_pix_data", pixel_data, 24'h010203);
        send(8'h04);
        chk("len_err_flag", len_err, 1);
        chk("len_no_2nd_pix", pixel_valid, 0);
        send(8'h00);
        chk("len_err_1cyc", len_err, 0);
        send(8'h00);

        $display("txn RGB888 truncated after 2 payload bytes");
        send_hdr(8'h3E, 8'h06, 8'h00, 8'h38);
        send(8'hAA); send(8'hBB);
        hs_active = 1'b0;
        byte_in   = 8'hCC;
        byte_valid = 1'b1;
        @(posedge clk); #1;
        byte_valid = 1'b0;
        chk("trunc_flag", trunc_err, 1);
        chk("trunc_no_pix", pixel_valid, 0);
        idle();
        chk("trunc_1cyc", trunc_err, 0);
        chk("trunc_pd_hold", pixel_data, 24'h010203);
        $display("txn VSS after truncation");
        send_hdr(8'h01, 8'h00, 8'h00, 8'h01);
        chk("trunc_back_to_h0", vsync, 1);

        $display("txn VSS on VC1 41 00 00 41");
        send_hdr(8'h41, 8'h00, 8'h00, 8'h41);
        chk("vc_filter_vsync", vsync, 0);
        chk("vc_filter_ecc", ecc_err, 0);

        $display("txn RGB888 reset mid-payload");
        send_hdr(8'h3E, 8'h06, 8'h00, 8'h38);
        send(8'h77); send(8'h88);
        idle(); idle();
        chk("pre_reset_pd", pixel_data, 24'h010203);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        $display("txn RGB888 WC=3 after reset");
        send_hdr(8'h3E, 8'h03, 8'h00, 8'h3D);
        send(8'h10); send(8'h20); send(8'h30);
        chk("post_rst_pix_valid", pixel_valid, 1);
        chk("post_rst_pix_data", pixel_data, 24'h102030);
        chk("post_rst_no_len_err", len_err, 0);
        send(8'h00); send(8'h00);
        idle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
